// File: rtl/xspi_fifo_ctrl.sv
// Valid/ready FIFO controller around a 1W/1R RAM with one-cycle registered read.
// A 2-entry output buffer fed by read prefetch gives show-ahead, full-rate output.
module xspi_fifo_ctrl #(
  parameter int PTR_WIDTH   = 3,
  parameter int DATA_WIDTH  = 39,
  parameter int DEPTH       = 7,
  parameter int AFULL_LEVEL = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [PTR_WIDTH-1:0]  mem_waddr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [PTR_WIDTH-1:0]  mem_raddr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [PTR_WIDTH:0]    count,
  output logic                  almost_full
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0]        LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]        LP_AFULL = CW'(AFULL_LEVEL);
  localparam logic [PTR_WIDTH-1:0] LP_LAST  = PTR_WIDTH'(DEPTH - 1);

  logic [PTR_WIDTH-1:0]  r_wptr;
  logic [PTR_WIDTH-1:0]  r_rptr;
  logic [CW-1:0]         r_mem_cnt;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_ob [2];
  logic                  r_head;
  logic [1:0]            r_ob_cnt;

  logic       w_push;
  logic       w_pop;
  logic       w_fetch;
  logic       w_tail;
  logic [2:0] w_pending;

  function automatic logic [PTR_WIDTH-1:0] f_next_ptr(input logic [PTR_WIDTH-1:0] p);
    return (p == LP_LAST) ? '0 : p + 1'b1;
  endfunction

  assign s_ready   = ~clr & (r_mem_cnt < LP_DEPTH);
  assign w_push    = s_valid & s_ready;
  assign m_valid   = (r_ob_cnt != 2'd0);
  assign w_pop     = m_valid & m_ready;
  assign m_data    = r_ob[r_head];

  // Prefetch only while buffer slots (after this cycle's pop) outnumber reads in flight.
  assign w_pending = {1'b0, r_ob_cnt} + {2'b00, r_inflight};
  assign w_fetch   = ~clr & (r_mem_cnt != '0) & (w_pending < (3'd2 + {2'b00, w_pop}));

  // The buffer never holds two entries when a read returns, so the tail is head+ob_cnt[0].
  assign w_tail    = r_head ^ r_ob_cnt[0];

  assign mem_wen   = w_push;
  assign mem_waddr = r_wptr;
  assign mem_wdata = s_data;
  assign mem_ren   = w_fetch;
  assign mem_raddr = r_rptr;

  assign count       = r_mem_cnt + CW'(r_inflight) + CW'(r_ob_cnt);
  assign almost_full = (count >= LP_AFULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_ob_cnt   <= 2'd0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_ob_cnt   <= 2'd0;
    end else begin
      if (w_push)  r_wptr <= f_next_ptr(r_wptr);
      if (w_fetch) r_rptr <= f_next_ptr(r_rptr);
      r_mem_cnt  <= r_mem_cnt + CW'(w_push) - CW'(w_fetch);
      r_inflight <= w_fetch;
      if (w_pop) r_head <= ~r_head;
      r_ob_cnt   <= r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ob[0] <= '0;
      r_ob[1] <= '0;
    end else if (r_inflight && !clr) begin
      r_ob[w_tail] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_xspi_fifo_ctrl.sv
// Scoreboard bench for xspi_fifo_ctrl: queue reference model, RAM model, directed
// boundary scenarios plus randomized traffic.
module tb_xspi_fifo_ctrl;
  localparam int PW = 3;
  localparam int DW = 39;
  localparam int DEPTH = 7;
  localparam int AFULL = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [PW-1:0] mem_waddr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [PW-1:0] mem_raddr;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata = '0;
  logic [PW:0]   count;
  logic          almost_full;

  xspi_fifo_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [2**PW];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_raddr];
  end

  logic [DW-1:0] q[$];
  int checks = 0;
  int errors = 0;
  int exp_wa = 0;
  int exp_ra = 0;
  logic last_acc = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[DW-1:0];
  endfunction

  // One clock cycle: drive at posedge+1, record accepted writes in the model after negedge.
  task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic c);
    @(posedge clk); #1;
    s_valid = sv; s_data = sd; m_ready = mr; clr = c;
    @(negedge clk); #1;
    last_acc = 1'b0;
    if (!rst) begin
      if (clr) begin
        q.delete();
        exp_wa = 0;
      end else if (s_valid && s_ready) begin
        q.push_back(s_data);
        exp_wa = (exp_wa + 1) % DEPTH;
        last_acc = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_complete", 64'(q.size()), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: compares at negedge, before the driver updates the model for this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count_vs_model", 64'(count), 64'(q.size()));
      chk("almost_full", 64'(almost_full), 64'(q.size() >= AFULL));
      if (q.size() >= DEPTH + 2) chk("s_ready_when_full", 64'(s_ready), 64'd0);
      if (mem_wen) begin
        chk("mem_waddr_seq", 64'(mem_waddr), 64'(exp_wa));
        chk("mem_wdata", 64'(mem_wdata), 64'(s_data));
        if (mem_ren) chk("raddr_ne_waddr", 64'(mem_raddr == mem_waddr), 64'd0);
      end
      if (clr) begin
        chk("clr_ren_low", 64'(mem_ren), 64'd0);
        exp_ra = 0;
      end else begin
        if (mem_ren) begin
          chk("mem_raddr_seq", 64'(mem_raddr), 64'(exp_ra));
          exp_ra = (exp_ra + 1) % DEPTH;
        end
        if (m_valid && m_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_unexpected: got %0h expected no output", m_data);
          end else begin
            chk("pop_data", 64'(m_data), 64'(q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int acc;
    int c10;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_wen", 64'(mem_wen), 64'd0);
    chk("rst_ren", 64'(mem_ren), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_raddr", 64'(mem_raddr), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd1);

    // Fill with consumer stalled, then drain in order
    acc = 0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      if (last_acc) acc++;
    end
    chk("fill_10th_rejected", 64'(last_acc), 64'd0);
    chk("fill_accepted", 64'(acc), 64'd9);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'd9);
    chk("fill_afull", 64'(almost_full), 64'd1);
    chk("fill_head", 64'(m_data), 64'h01);
    drain();

    // Latency into empty FIFO
    drive(1'b1, DW'(8'h55), 1'b0, 1'b0);
    chk("lat_T_wen", 64'(mem_wen), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lat_T1_ren", 64'(mem_ren), 64'd1);
    chk("lat_T1_mvalid", 64'(m_valid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lat_T2_mvalid", 64'(m_valid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lat_T3_mvalid", 64'(m_valid), 64'd1);
    chk("lat_T3_mdata", 64'(m_data), 64'h55);
    drain();

    // Streaming at full rate
    c10 = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rnd_data(), 1'b1, 1'b0);
      chk("stream_s_ready", 64'(s_ready), 64'd1);
      if (i == 9) c10 = int'(count);
      if (i > 9) begin
        chk("stream_count_steady", 64'(count), 64'(c10));
        chk("stream_pop_each_cycle", 64'(m_valid), 64'd1);
      end
    end
    drain();

    // Random traffic across many pointer wraps
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 3) != 0), rnd_data(), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Full RAM: pop frees buffer slot, fetch happens while writes stay blocked
    for (int i = 0; i < 12; i++) drive(1'b1, rnd_data(), 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'(DEPTH + 2));
    drive(1'b1, rnd_data(), 1'b1, 1'b0);
    chk("full_s_ready_low", 64'(s_ready), 64'd0);
    chk("full_fetch", 64'(mem_ren), 64'd1);
    for (int i = 0; i < 10; i++) drive(1'b1, rnd_data(), 1'b1, 1'b0);
    drain();

    // clr mid-stream with a read in flight
    for (int i = 0; i < 6; i++) drive(1'b1, rnd_data(), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, DW'(8'hEE), 1'b1, 1'b1);
    chk("clr_s_ready", 64'(s_ready), 64'd0);
    chk("clr_no_ren", 64'(mem_ren), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_m_valid", 64'(m_valid), 64'd0);
    drive(1'b1, DW'(8'h3C), 1'b0, 1'b0);
    drain();

    // Async reset while half full
    for (int i = 0; i < 4; i++) drive(1'b1, rnd_data(), 1'b0, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_m_data", 64'(m_data), 64'd0);
    chk("arst_ren", 64'(mem_ren), 64'd0);
    chk("arst_addrs", 64'({mem_waddr, mem_raddr}), 64'd0);
    q.delete();
    exp_wa = 0;
    exp_ra = 0;
    @(negedge clk); #2;
    rst = 1'b0;
    drive(1'b1, DW'(8'hAA), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("arst_T2_mvalid", 64'(m_valid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("arst_T3_mvalid", 64'(m_valid), 64'd1);
    chk("arst_T3_mdata", 64'(m_data), 64'hAA);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
